// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, width default and entry types for the ALU result stage
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_OPW   = 5;

    localparam logic [ALU_OPW-1:0] OP_ADD = 5'b00000;
    localparam logic [ALU_OPW-1:0] OP_SUB = 5'b00001;
    localparam logic [ALU_OPW-1:0] OP_AND = 5'b00010;
    localparam logic [ALU_OPW-1:0] OP_OR  = 5'b00011;
    localparam logic [ALU_OPW-1:0] OP_SLL = 5'b00100;
    localparam logic [ALU_OPW-1:0] OP_SRA = 5'b00101;

    typedef struct packed {
        logic overflow;
        logic is_not_equal;
        logic is_less_than;
        logic illegal_op;
    } alu_flags_t;

    localparam int ALU_FLAGS_W = $bits(alu_flags_t);

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        alu_flags_t           flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// rtl/alu_skid_buffer.sv - generic 2-entry valid/ready skid buffer, ready driven only from a register
module alu_skid_buffer #(
    parameter int DW = 36
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          m_valid_q, m_valid_d;
    logic          s_valid_q, s_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic [DW-1:0] s_data_q, s_data_d;
    logic          acc;
    logic          pop;

    assign in_ready  = !s_valid_q;
    assign acc       = in_valid && !s_valid_q;
    assign pop       = m_valid_q && out_ready;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;

    // S is only ever occupied while M is occupied, so M-empty never needs S.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        if (!m_valid_q) begin
            if (acc) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
            end
        end else if (pop) begin
            if (s_valid_q) begin
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (acc) begin
                m_data_d = in_data;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (acc) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - ALU result select and flag derivation feeding a registered skid buffer
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic             op_a_msb,
    input  logic             op_b_msb,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] and_in,
    input  logic [WIDTH-1:0] or_in,
    input  logic [WIDTH-1:0] sll_in,
    input  logic [WIDTH-1:0] sra_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             is_not_equal,
    output logic             is_less_than,
    output logic             illegal_op
);

    localparam int PW = WIDTH + ALU_FLAGS_W;

    logic [WIDTH-1:0] sel_result;
    alu_flags_t       sel_flags;
    alu_flags_t       out_flags;
    logic             sum_msb;
    logic [PW-1:0]    out_payload;

    assign sum_msb = sum_in[WIDTH-1];

    always_comb begin
        sel_result = '0;
        sel_flags  = '0;
        case (opcode)
            OPW'(OP_ADD): begin
                sel_result         = sum_in;
                sel_flags.overflow = (op_a_msb == op_b_msb) && (sum_msb != op_a_msb);
            end
            OPW'(OP_SUB): begin
                sel_result             = sum_in;
                sel_flags.overflow     = (op_a_msb != op_b_msb) && (sum_msb != op_a_msb);
                sel_flags.is_not_equal = |sum_in;
                sel_flags.is_less_than = sum_msb ^ sel_flags.overflow;
            end
            OPW'(OP_AND): sel_result = and_in;
            OPW'(OP_OR):  sel_result = or_in;
            OPW'(OP_SLL): sel_result = sll_in;
            OPW'(OP_SRA): sel_result = sra_in;
            default:      sel_flags.illegal_op = 1'b1;
        endcase
    end

    alu_skid_buffer #(
        .DW(PW)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({sel_result, sel_flags}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign result       = out_payload[PW-1:ALU_FLAGS_W];
    assign out_flags    = out_payload[ALU_FLAGS_W-1:0];
    assign overflow     = out_flags.overflow;
    assign is_not_equal = out_flags.is_not_equal;
    assign is_less_than = out_flags.is_less_than;
    assign illegal_op   = out_flags.illegal_op;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - directed self-checking bench for alu_result_stage
module tb_alu_result_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic        op_a_msb;
    logic        op_b_msb;
    logic [31:0] sum_in;
    logic [31:0] and_in;
    logic [31:0] or_in;
    logic [31:0] sll_in;
    logic [31:0] sra_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        is_not_equal;
    logic        is_less_than;
    logic        illegal_op;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_result_stage dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .op_a_msb    (op_a_msb),
        .op_b_msb    (op_b_msb),
        .sum_in      (sum_in),
        .and_in      (and_in),
        .or_in       (or_in),
        .sll_in      (sll_in),
        .sra_in      (sra_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .is_not_equal(is_not_equal),
        .is_less_than(is_less_than),
        .illegal_op  (illegal_op)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic v, input logic [4:0] op, input logic am, input logic bm,
                         input logic [31:0] s, input logic [31:0] a, input logic [31:0] o,
                         input logic [31:0] l, input logic [31:0] r);
        in_valid = v;
        opcode   = op;
        op_a_msb = am;
        op_b_msb = bm;
        sum_in   = s;
        and_in   = a;
        or_in    = o;
        sll_in   = l;
        sra_in   = r;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 5'b00000, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 32'h4);
        step();
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        total_cnt++;
        if ({result, overflow, is_not_equal, is_less_than, illegal_op} !== 36'h0)
            $display("FAIL reset_payload: got %h/%b%b%b%b want 0/0000", result,
                     overflow, is_not_equal, is_less_than, illegal_op);
        else pass_cnt++;
        reset = 1'b0;
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_add_overflow();
        out_ready = 1'b1;
        drive(1'b1, 5'b00000, 1'b0, 1'b0, 32'h8000_0000, 32'h11, 32'h22, 32'h33, 32'h44);
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || result !== 32'h8000_0000)
            $display("FAIL add_result: got v=%b %h want v=1 80000000", out_valid, result);
        else pass_cnt++;
        total_cnt++;
        if ({overflow, is_not_equal, is_less_than, illegal_op} !== 4'b1000)
            $display("FAIL add_flags: got %b%b%b%b want 1000", overflow, is_not_equal,
                     is_less_than, illegal_op);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL add_drained: got %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_sub_flags();
        logic [4:0]  am_bm_vec [3];
        logic [31:0] sum_vec   [3];
        logic [3:0]  exp_flags [3];
        am_bm_vec[0] = 5'b00010; sum_vec[0] = 32'h7FFF_FFFF; exp_flags[0] = 4'b1110;
        am_bm_vec[1] = 5'b00000; sum_vec[1] = 32'h0000_0000; exp_flags[1] = 4'b0000;
        am_bm_vec[2] = 5'b00000; sum_vec[2] = 32'hFFFF_FFFF; exp_flags[2] = 4'b0110;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'b00001, am_bm_vec[i][1], am_bm_vec[i][0], sum_vec[i],
                  32'h55, 32'h66, 32'h77, 32'h88);
            step();
            total_cnt++;
            if (out_valid !== 1'b1 || result !== sum_vec[i] ||
                {overflow, is_not_equal, is_less_than, illegal_op} !== exp_flags[i])
                $display("FAIL sub_%0d: got v=%b %h %b%b%b%b want v=1 %h %b", i, out_valid,
                         result, overflow, is_not_equal, is_less_than, illegal_op,
                         sum_vec[i], exp_flags[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_shift_and_logic();
        logic [4:0]  op_vec  [4];
        logic [31:0] exp_vec [4];
        op_vec[0] = 5'b00101; exp_vec[0] = 32'hFFFF_FFFF;
        op_vec[1] = 5'b00100; exp_vec[1] = 32'h8000_0000;
        op_vec[2] = 5'b00010; exp_vec[2] = 32'h0F0F_0F0F;
        op_vec[3] = 5'b00011; exp_vec[3] = 32'hF0F0_FFFF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, op_vec[i], 1'b0, 1'b0, 32'h8000_0001, 32'h0F0F_0F0F,
                  32'hF0F0_FFFF, 32'h8000_0000, 32'hFFFF_FFFF);
            step();
            total_cnt++;
            if (out_valid !== 1'b1 || result !== exp_vec[i] ||
                {overflow, is_not_equal, is_less_than, illegal_op} !== 4'b0000)
                $display("FAIL pass_%0d: got v=%b %h %b%b%b%b want v=1 %h 0000", i, out_valid,
                         result, overflow, is_not_equal, is_less_than, illegal_op, exp_vec[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_pressure();
        int acc_cnt = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'b00000, 1'b0, 1'b0, 32'hA0 + i, 32'h0, 32'h0, 32'h0, 32'h0);
            if (in_ready === 1'b1) acc_cnt++;
            step();
            if (i == 1) begin
                total_cnt++;
                if (in_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", in_ready);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        total_cnt++;
        if (acc_cnt != 2) $display("FAIL bp_accept_count: got %0d want 2", acc_cnt);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || result !== 32'hA0 || in_ready !== 1'b0)
            $display("FAIL bp_hold: got v=%b %h rdy=%b want v=1 000000a0 rdy=0",
                     out_valid, result, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        total_cnt++;
        if (out_valid !== 1'b1 || result !== 32'hA1 || in_ready !== 1'b1)
            $display("FAIL bp_drain1: got v=%b %h rdy=%b want v=1 000000a1 rdy=1",
                     out_valid, result, in_ready);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain_empty: got %b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(1'b1, 5'b00111, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h3, 32'h4);
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || result !== 32'h0 ||
            {overflow, is_not_equal, is_less_than, illegal_op} !== 4'b0001)
            $display("FAIL illegal_op: got v=%b %h %b%b%b%b want v=1 00000000 0001", out_valid,
                     result, overflow, is_not_equal, is_less_than, illegal_op);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(1'b1, 5'b00011, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC1, 32'h0, 32'h0);
        step();
        or_in = 32'hC2;
        step();
        total_cnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL mid_full: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
        else pass_cnt++;
        reset = 1'b1;
        or_in = 32'hC3;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0)
            $display("FAIL mid_reset: got v=%b rdy=%b %h want v=0 rdy=1 00000000",
                     out_valid, in_ready, result);
        else pass_cnt++;
        out_ready = 1'b1;
        drive(1'b1, 5'b00011, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC4, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || result !== 32'hC4)
            $display("FAIL mid_post: got v=%b %h want v=1 000000c4", out_valid, result);
        else pass_cnt++;
        step();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL mid_post_empty: got %b want 0", out_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_flags();
        test_shift_and_logic();
        test_back_pressure();
        test_illegal();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
